// File: rtl/alu_seq.sv
// Multi-cycle ALU with a valid/ready handshake. Logic, arithmetic, shift and rotate
// ops finish in one cycle. Multiply (Booth) and divide (restoring) take one bit per cycle.
module alu_seq #(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           zero,
  output logic           dz,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_SHL  = 5'd6,  OP_SHR  = 5'd7;
  localparam logic [4:0] OP_ROTL = 5'd8,  OP_ROTR = 5'd9,  OP_NOT  = 5'd10, OP_XOR  = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12, OP_NAND = 5'd13;

  state_e         state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [W:0]     hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d, m_q, m_d;
  logic           q1_q, q1_d;
  logic [4:0]     op_q, op_d;
  logic           neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_pend_q, dz_pend_d;
  logic [2*W-1:0] result_q, result_d;
  logic           zero_q, zero_d, dz_q, dz_d, err_q, err_d;

  logic           accept, last_iter, iterate, w_q1;
  logic [SW-1:0]  sh, neg_sh;
  logic [W-1:0]   alu_f, a_mag, b_mag, w_lo, w_m, quo, rem;
  logic [W:0]     w_hi, sum, shifted, trial;
  logic [4:0]     w_op;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt_q == SW'(W - 1));
  assign a_mag     = a[W-1] ? -a : a;
  assign b_mag     = b[W-1] ? -b : b;

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op == OP_MUL)      state_d = S_MUL;
          else if (op == OP_DIV) state_d = (b == '0) ? S_FIX : S_DIV;
          else                   state_d = S_DONE;
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_FIX;
      S_FIX:        state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    out_valid = (state_q == S_DONE);
  end

  // Rotates use (W - sh) mod W as the opposite shift; sh = 0 collapses to b | b.
  always_comb begin
    sh     = a[SW-1:0];
    neg_sh = -sh;
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NOR:  alu_f = ~(a | b);
      OP_NAND: alu_f = ~(a & b);
      OP_SHL:  alu_f = b << sh;
      OP_SHR:  alu_f = b >> sh;
      OP_ROTL: alu_f = (b << sh) | (b >> neg_sh);
      OP_ROTR: alu_f = (b >> sh) | (b << neg_sh);
      OP_NOT:  alu_f = ~b;
      default: alu_f = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    cnt_d = cnt_q; hi_d = hi_q; lo_d = lo_q; q1_d = q1_q; m_d = m_q; op_d = op_q;
    neg_quo_d = neg_quo_q; neg_rem_d = neg_rem_q; dz_pend_d = dz_pend_q;
    result_d = result_q; dz_d = dz_q; err_d = err_q;
    w_hi = hi_q; w_lo = lo_q; w_q1 = q1_q; w_m = m_q; w_op = op_q;
    sum = '0; shifted = '0; trial = '0; quo = '0; rem = '0;
    iterate = (state_q == S_MUL) || (state_q == S_DIV);

    // The accept edge loads the operands and also performs the first iteration.
    if (accept) begin
      w_op = op; w_hi = '0; w_q1 = 1'b0;
      w_m  = (op == OP_DIV) ? b_mag : a;
      w_lo = (op == OP_DIV) ? ((b == '0) ? a : a_mag) : b;
      op_d = op; hi_d = w_hi; lo_d = w_lo; q1_d = w_q1; m_d = w_m;
      neg_quo_d = a[W-1] ^ b[W-1];
      neg_rem_d = a[W-1];
      dz_pend_d = (b == '0);
      iterate   = (op == OP_MUL) || (op == OP_DIV && b != '0);
      if (op != OP_MUL && op != OP_DIV) begin
        result_d = {{W{1'b0}}, alu_f};
        err_d    = (op > OP_NAND);
        dz_d     = 1'b0;
      end
    end

    if (iterate) begin
      if (w_op == OP_MUL) begin
        case ({w_lo[0], w_q1})
          2'b01:   sum = w_hi + {w_m[W-1], w_m};
          2'b10:   sum = w_hi - {w_m[W-1], w_m};
          default: sum = w_hi;
        endcase
        {hi_d, lo_d, q1_d} = {sum[W], sum, w_lo};
      end else begin
        shifted = {w_hi[W-1:0], w_lo[W-1]};
        trial   = shifted - {1'b0, w_m};
        hi_d    = trial[W] ? shifted : trial;
        lo_d    = {w_lo[W-2:0], ~trial[W]};
      end
      cnt_d = last_iter ? '0 : cnt_q + SW'(1);
    end

    if (state_q == S_FIX) begin
      quo   = neg_quo_q ? -lo_q : lo_q;
      rem   = neg_rem_q ? -hi_q[W-1:0] : hi_q[W-1:0];
      err_d = 1'b0;
      dz_d  = 1'b0;
      if (op_q == OP_MUL) begin
        result_d = {hi_q[W-1:0], lo_q};
      end else if (dz_pend_q) begin
        result_d = {lo_q, {W{1'b1}}};
        dz_d     = 1'b1;
      end else begin
        result_d = {rem, quo};
      end
    end

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      dz_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      dz_q      <= dz_d;
      err_q     <= err_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign dz     = dz_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W = 32). It applies a vector table, random operations
// scored against an arithmetic reference model, and hand-written handshake and reset sequences.
module tb_alu_seq;
  localparam int W  = 32;
  localparam int NV = 14;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]    op_i = '0;
  logic [W-1:0]  a_i = '0, b_i = '0;
  logic          in_ready, out_valid, zero, dz, err;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op_i), .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .dz(dz), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] res;
    logic        dz, err;
    int          lat;
  } vec_t;

  vec_t       vecs [NV];
  logic [4:0] single_ops [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain signed arithmetic on 64-bit integers and bit-by-bit rotation.
  function automatic void ref_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [63:0] r, output logic d, output logic e,
                                    output int lat);
    longint      sx, sy;
    logic [31:0] v;
    int          s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = int'(x[4:0]);
    v  = y;
    r = '0; d = 1'b0; e = 1'b0; lat = 1;
    case (o)
      5'd0:  r = {32'd0, x + y};
      5'd1:  r = {32'd0, x - y};
      5'd2:  begin r = 64'(sx * sy); lat = W + 1; end
      5'd3:  begin
        if (y == 0) begin
          r = {x, 32'hFFFF_FFFF}; d = 1'b1; lat = 2;
        end else begin
          r = {32'(sx % sy), 32'(sx / sy)}; lat = W + 1;
        end
      end
      5'd4:  r = {32'd0, x & y};
      5'd5:  r = {32'd0, x | y};
      5'd6:  r = {32'd0, y << s};
      5'd7:  r = {32'd0, y >> s};
      5'd8:  begin for (int i = 0; i < s; i++) v = {v[30:0], v[31]}; r = {32'd0, v}; end
      5'd9:  begin for (int i = 0; i < s; i++) v = {v[0], v[31:1]}; r = {32'd0, v}; end
      5'd10: r = {32'd0, ~y};
      5'd11: r = {32'd0, x ^ y};
      5'd12: r = {32'd0, ~(x | y)};
      5'd13: r = {32'd0, ~(x & y)};
      default: e = 1'b1;
    endcase
  endfunction

  // Issues one operation, scrambles the inputs after acceptance, and waits for the result.
  // Entered and left #1 after a rising edge.
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] r, output logic z, output logic d, output logic e,
                        output int lat, output logic busy_rdy);
    int n;
    op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_i = 5'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1; busy_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
    r = result; z = zero; d = dz; e = err;
  endtask

  initial begin
    logic [63:0] r, er;
    logic        z, d, e, busy, ed, ee, stale;
    int          lat, el;
    logic [4:0]  o;
    logic [31:0] x, y;

    single_ops = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
    vecs[0]  = '{5'd0,  32'hFFFF_FFFF, 32'd1,         64'h0,                   1'b0, 1'b0, 1};
    vecs[1]  = '{5'd2,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 33};
    vecs[2]  = '{5'd3,  32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 33};
    vecs[3]  = '{5'd3,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b1, 1'b0, 2};
    vecs[4]  = '{5'd8,  32'd4,         32'h8000_0001, 64'h18,                  1'b0, 1'b0, 1};
    vecs[5]  = '{5'd6,  32'd4,         32'd1,         64'h10,                  1'b0, 1'b0, 1};
    vecs[6]  = '{5'd20, 32'h1234,      32'h5678,      64'h0,                   1'b0, 1'b1, 1};
    vecs[7]  = '{5'd3,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 33};
    vecs[8]  = '{5'd2,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 33};
    vecs[9]  = '{5'd1,  32'd0,         32'd1,         64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1};
    vecs[10] = '{5'd9,  32'd1,         32'd1,         64'h8000_0000,           1'b0, 1'b0, 1};
    vecs[11] = '{5'd7,  32'h1F,        32'h8000_0000, 64'h1,                   1'b0, 1'b0, 1};
    vecs[12] = '{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0,                   1'b0, 1'b0, 1};
    vecs[13] = '{5'd3,  32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 33};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    result,         64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_dz",        64'(dz),        64'd0);
    check("rst_err",       64'(err),       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, d, e, lat, busy);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 64'(z), 64'(vecs[i].res == 64'd0));
      check($sformatf("vec%0d_dz", i), 64'(d), 64'(vecs[i].dz));
      check($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].err));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      if (vecs[i].lat > 1) check($sformatf("vec%0d_busy_in_ready", i), 64'(busy), 64'd0);
    end

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       o = 5'd2;
        1:       o = 5'd3;
        default: o = 5'($urandom_range(0, 31));
      endcase
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      ref_model(o, x, y, er, ed, ee, el);
      run_op(o, x, y, r, z, d, e, lat, busy);
      check($sformatf("rnd%0d_op%0d_result", i, o), r, er);
      check($sformatf("rnd%0d_op%0d_flags", i, o), {61'd0, z, d, e}, {61'd0, er == 64'd0, ed, ee});
      check($sformatf("rnd%0d_op%0d_latency", i, o), 64'(lat), 64'(el));
    end

    // Backpressure: result and flags hold while out_ready is low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(5'd3, 32'd5, 32'd0, r, z, d, e, lat, busy);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d_result", i), result, 64'h0000_0005_FFFF_FFFF);
      check($sformatf("bp%0d_flags", i), {61'd0, zero, dz, err}, 64'b010);
    end

    // Consume and accept on the same edge.
    op_i = 5'd11; a_i = 32'hF0; b_i = 32'hFF; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("swap_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("swap_out_valid", 64'(out_valid), 64'd1);
    check("swap_result", result, 64'h0F);
    check("swap_dz", 64'(dz), 64'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    for (int i = 0; i < 8; i++) begin
      o = single_ops[$urandom_range(0, 11)];
      x = $urandom; y = $urandom;
      ref_model(o, x, y, er, ed, ee, el);
      op_i = o; a_i = x; b_i = y; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("b2b%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("b2b%0d_result", i), result, er);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    op_i = 5'd2; a_i = $urandom; b_i = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy_in_ready", 64'(in_ready), 64'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_result",    result,         64'd0);
    check("mid_rst_zero",      64'(zero),      64'd1);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("mid_rst_no_stale", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
